eth_frame_monitor: RTL and testbench

Downstream of eth_sw. Consumes the switch egress word stream (outDataA/outSopA/outEopA/outvld) and checks frame structure, length and destination-address class. Forwards the stream with one cycle of latency. Flags each frame as good or bad and keeps saturating statistics counters for the bench and for later register access.

---
 rtl/eth_pkg.sv | 39 +++
 rtl/eth_sat_counter.sv | 22 ++
 rtl/eth_frame_monitor.sv | 179 +++++++++++++++++
 tb/tb_eth_frame_monitor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and field positions for the Ethernet egress frame monitor.
package eth_pkg;

  localparam int WORD_W = 64;
  localparam int DA_HI  = 63;
  localparam int DA_LO  = 16;
  localparam int IG_BIT = 40;

  localparam logic [47:0] ETH_BCAST = 48'hFFFF_FFFF_FFFF;

  // Slot of each statistics counter in the counter bank
  localparam int ST_GOOD  = 0;
  localparam int ST_BAD   = 1;
  localparam int ST_BCAST = 2;
  localparam int ST_MCAST = 3;
  localparam int ST_UCAST = 4;
  localparam int ST_STRAY = 5;
  localparam int ST_NUM   = 6;

  typedef enum logic {
    IDLE,
    IN_FRAME
  } mon_state_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_RUNT  = 3'd1,
    ERR_GIANT = 3'd2,
    ERR_SOP   = 3'd3,
    ERR_GAP   = 3'd4
  } err_code_t;

  typedef struct packed {
    logic        vld;
    err_code_t   code;
    logic [47:0] da;
  } frame_end_t;

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module eth_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/eth_frame_monitor.sv
// Checks egress frame structure, length and DA class; forwards the word stream
// one cycle late and reports one frame end per cycle with saturating statistics.
module eth_frame_monitor
  import eth_pkg::*;
#(
  parameter int MIN_WORDS = 8,
  parameter int MAX_WORDS = 190,
  parameter int GAP_MAX   = 4,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [WORD_W-1:0]  inData,
  input  logic               inSop,
  input  logic               inEop,
  input  logic               inVld,
  input  logic [47:0]        cfgMacAddr,
  input  logic               statClr,
  output logic [WORD_W-1:0]  outData,
  output logic               outSop,
  output logic               outEop,
  output logic               outVld,
  output logic               outFrameOk,
  output logic               outFrameErr,
  output logic [2:0]         outErrCode,
  output logic               outDaMatch,
  output logic [COUNT_W-1:0] statGood,
  output logic [COUNT_W-1:0] statBad,
  output logic [COUNT_W-1:0] statBcast,
  output logic [COUNT_W-1:0] statMcast,
  output logic [COUNT_W-1:0] statUcast,
  output logic [COUNT_W-1:0] statStray
);

  localparam int CNT_W = $clog2(MAX_WORDS + 2);
  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WORDS + 1);

  mon_state_t       state, state_next;
  logic [CNT_W-1:0] word_cnt, word_cnt_next, word_cnt_inc;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
  logic [47:0]      da, da_next, in_da;
  frame_end_t       pend, pend_next, cur_end, second_end, fire;
  logic             stray;
  logic             fire_bcast;
  logic [ST_NUM-1:0] cnt_inc;
  logic [COUNT_W-1:0] cnt_val [ST_NUM];

  function automatic err_code_t len_code(input logic [CNT_W-1:0] n);
    if (n < CNT_W'(MIN_WORDS)) return ERR_RUNT;
    if (n > CNT_W'(MAX_WORDS)) return ERR_GIANT;
    return ERR_NONE;
  endfunction

  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    gap_cnt_next  = gap_cnt;
    da_next       = da;
    cur_end       = '0;
    second_end    = '0;
    stray         = 1'b0;
    in_da         = inData[DA_HI:DA_LO];
    word_cnt_inc  = (word_cnt >= CNT_SAT) ? CNT_SAT : word_cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        if (inVld) begin
          if (inSop) begin
            da_next       = in_da;
            word_cnt_next = CNT_W'(1);
            gap_cnt_next  = '0;
            if (inEop) cur_end = '{1'b1, len_code(CNT_W'(1)), in_da};
            else       state_next = IN_FRAME;
          end else begin
            stray = 1'b1;
          end
        end
      end
      IN_FRAME: begin
        if (inVld) begin
          gap_cnt_next = '0;
          if (inSop) begin
            // The interrupting SOP both closes the old frame and opens a new one
            cur_end       = '{1'b1, ERR_SOP, da};
            da_next       = in_da;
            word_cnt_next = CNT_W'(1);
            if (inEop) begin
              second_end = '{1'b1, len_code(CNT_W'(1)), in_da};
              state_next = IDLE;
            end
          end else begin
            word_cnt_next = word_cnt_inc;
            if (inEop) begin
              cur_end    = '{1'b1, len_code(word_cnt_inc), da};
              state_next = IDLE;
            end
          end
        end else if (gap_cnt == GAP_W'(GAP_MAX - 1)) begin
          cur_end      = '{1'b1, ERR_GAP, da};
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt + GAP_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // At most one frame end is reported per cycle; a held-over end goes first.
    if (pend.vld) begin
      fire      = pend;
      pend_next = cur_end;
    end else begin
      fire      = cur_end;
      pend_next = second_end;
    end

    fire_bcast          = (fire.da == ETH_BCAST);
    cnt_inc[ST_GOOD]    = fire.vld && (fire.code == ERR_NONE);
    cnt_inc[ST_BAD]     = fire.vld && (fire.code != ERR_NONE);
    cnt_inc[ST_BCAST]   = fire.vld && fire_bcast;
    cnt_inc[ST_MCAST]   = fire.vld && !fire_bcast && fire.da[IG_BIT];
    cnt_inc[ST_UCAST]   = fire.vld && !fire_bcast && !fire.da[IG_BIT];
    cnt_inc[ST_STRAY]   = stray;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      da          <= '0;
      pend        <= '0;
      outData     <= '0;
      outSop      <= 1'b0;
      outEop      <= 1'b0;
      outVld      <= 1'b0;
      outFrameOk  <= 1'b0;
      outFrameErr <= 1'b0;
      outErrCode  <= '0;
      outDaMatch  <= 1'b0;
    end else begin
      state       <= state_next;
      word_cnt    <= word_cnt_next;
      gap_cnt     <= gap_cnt_next;
      da          <= da_next;
      pend        <= pend_next;
      if (inVld) outData <= inData;
      outSop      <= inVld && inSop;
      outEop      <= inVld && inEop && !stray;
      outVld      <= inVld && !stray;
      outFrameOk  <= fire.vld && (fire.code == ERR_NONE);
      outFrameErr <= fire.vld && (fire.code != ERR_NONE);
      if (fire.vld) begin
        outErrCode <= fire.code;
        outDaMatch <= fire_bcast || (fire.da == cfgMacAddr);
      end
    end
  end

  for (genvar gi = 0; gi < ST_NUM; gi++) begin : g_stat
    eth_sat_counter #(.W(COUNT_W)) u_cnt (
      .clk    (clk),
      .resetN (resetN),
      .inc    (cnt_inc[gi]),
      .clr    (statClr),
      .count  (cnt_val[gi])
    );
  end

  assign statGood  = cnt_val[ST_GOOD];
  assign statBad   = cnt_val[ST_BAD];
  assign statBcast = cnt_val[ST_BCAST];
  assign statMcast = cnt_val[ST_MCAST];
  assign statUcast = cnt_val[ST_UCAST];
  assign statStray = cnt_val[ST_STRAY];

endmodule

// File: tb/tb_eth_frame_monitor.sv
// Randomized frame-level bench for eth_frame_monitor with a transaction-level reference model.
module tb_eth_frame_monitor;
  import eth_pkg::*;

  localparam int MIN_WORDS = 8;
  localparam int MAX_WORDS = 190;
  localparam int GAP_MAX   = 4;
  localparam int COUNT_W   = 16;
  localparam int CMAX      = (1 << COUNT_W) - 1;
  localparam logic [47:0] MY_MAC = 48'h0011_2233_4455;
  localparam logic [47:0] MC_MAC = 48'h0100_5E00_0001;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [63:0] inData = '0;
  logic inSop = 1'b0, inEop = 1'b0, inVld = 1'b0, statClr = 1'b0;
  logic [47:0] cfgMacAddr = MY_MAC;
  logic [63:0] outData;
  logic outSop, outEop, outVld, outFrameOk, outFrameErr, outDaMatch;
  logic [2:0] outErrCode;
  logic [COUNT_W-1:0] statGood, statBad, statBcast, statMcast, statUcast, statStray;

  always #5 clk = ~clk;

  eth_frame_monitor #(
    .MIN_WORDS(MIN_WORDS), .MAX_WORDS(MAX_WORDS), .GAP_MAX(GAP_MAX), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .resetN(resetN), .inData(inData), .inSop(inSop), .inEop(inEop),
    .inVld(inVld), .cfgMacAddr(cfgMacAddr), .statClr(statClr),
    .outData(outData), .outSop(outSop), .outEop(outEop), .outVld(outVld),
    .outFrameOk(outFrameOk), .outFrameErr(outFrameErr), .outErrCode(outErrCode),
    .outDaMatch(outDaMatch), .statGood(statGood), .statBad(statBad),
    .statBcast(statBcast), .statMcast(statMcast), .statUcast(statUcast),
    .statStray(statStray)
  );

  // Expected frame ends: reported one per cycle, in order, no earlier than the cycle after the event.
  typedef struct {
    int          pcyc;
    int          code;
    logic [47:0] da;
  } ev_t;

  ev_t evq[$];
  int cyc = 0;
  int last_pulse = -10;
  int n_cmp = 0;
  int n_bad = 0;
  int m_good = 0, m_bad = 0, m_bcast = 0, m_mcast = 0, m_ucast = 0, m_stray = 0;
  logic [63:0] m_data = '0;
  bit open_frame = 1'b0;
  logic [47:0] open_da = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  function automatic int len_code(input int n);
    if (n < MIN_WORDS) return 1;
    if (n > MAX_WORDS) return 2;
    return 0;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [47:0] pick_da();
    logic [47:0] d;
    d = 48'({$urandom, $urandom});
    case ($urandom_range(0, 4))
      0: d = MY_MAC;
      1: d = ETH_BCAST;
      2: d[IG_BIT] = 1'b1;
      3: d[IG_BIT] = 1'b0;
      default: ;
    endcase
    return d;
  endfunction

  task automatic push_ev(input int code, input logic [47:0] da);
    ev_t e;
    int t;
    t = cyc + 1;
    if (t <= last_pulse) t = last_pulse + 1;
    e.pcyc = t;
    e.code = code;
    e.da = da;
    last_pulse = t;
    evq.push_back(e);
  endtask

  task automatic model_clear();
    m_good = 0; m_bad = 0; m_bcast = 0; m_mcast = 0; m_ucast = 0; m_stray = 0;
  endtask

  // One input cycle: drive, let the DUT sample, then compare everything due one cycle later.
  task automatic step(input bit v, input bit s, input bit e, input logic [63:0] d,
                      input bit is_stray, input bit clr);
    ev_t ev;
    inVld = v; inSop = v & s; inEop = v & e; inData = d; statClr = clr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (v) m_data = d;
    check_val("out_vld", outVld, v && !is_stray);
    check_val("out_sop", outSop, v && s);
    check_val("out_eop", outEop, v && e && !is_stray);
    check_val("out_data", outData, m_data);
    if (is_stray) m_stray = sat_inc(m_stray);
    if (evq.size() > 0 && evq[0].pcyc == cyc) begin
      ev = evq.pop_front();
      check_val("frame_pulse", {outFrameOk, outFrameErr}, (ev.code == 0) ? 2'b10 : 2'b01);
      check_val("err_code", outErrCode, ev.code);
      check_val("da_match", outDaMatch, (ev.da == ETH_BCAST) || (ev.da == cfgMacAddr));
      $display("frame end @%0d: ok=%0b err=%0b code=%0d da=%h", cyc, outFrameOk, outFrameErr,
               outErrCode, ev.da);
      if (ev.code == 0) m_good = sat_inc(m_good);
      else              m_bad = sat_inc(m_bad);
      if (ev.da == ETH_BCAST)  m_bcast = sat_inc(m_bcast);
      else if (ev.da[IG_BIT])  m_mcast = sat_inc(m_mcast);
      else                     m_ucast = sat_inc(m_ucast);
    end else begin
      check_val("frame_pulse", {outFrameOk, outFrameErr}, 2'b00);
    end
    if (clr) model_clear();
    statClr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rnd64(), 1'b0, 1'b0);
  endtask

  task automatic strays(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd64(), 1'b1, 1'b0);
  endtask

  // Frame of len words; gaps inside it stay below the timeout.
  task automatic send_frame(input int len, input logic [47:0] da, input bit eop,
                            input int max_gap, input int fixed_gap);
    bit last;
    int g;
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      if (i > 0) begin
        g = (i == 2 && fixed_gap > 0) ? fixed_gap : int'($urandom_range(0, max_gap));
        idle(g);
      end
      if (i == 0) begin
        if (open_frame) push_ev(3, open_da);
        if (last && eop) push_ev(len_code(1), da);
        step(1'b1, 1'b1, last && eop, {da, 16'($urandom)}, 1'b0, 1'b0);
      end else begin
        if (last && eop) push_ev(len_code(len), da);
        step(1'b1, 1'b0, last && eop, rnd64(), 1'b0, 1'b0);
      end
    end
    open_frame = !eop;
    open_da = da;
  endtask

  task automatic send_gap_timeout(input int len, input logic [47:0] da);
    send_frame(len, da, 1'b0, GAP_MAX - 1, 0);
    for (int i = 1; i <= GAP_MAX; i++) begin
      if (i == GAP_MAX) push_ev(4, da);
      step(1'b0, 1'b0, 1'b0, rnd64(), 1'b0, 1'b0);
    end
    open_frame = 1'b0;
  endtask

  task automatic check_stats();
    check_val("stat_good", statGood, m_good);
    check_val("stat_bad", statBad, m_bad);
    check_val("stat_bcast", statBcast, m_bcast);
    check_val("stat_mcast", statMcast, m_mcast);
    check_val("stat_ucast", statUcast, m_ucast);
    check_val("stat_stray", statStray, m_stray);
  endtask

  task automatic check_zero();
    check_val("rst_out_data", outData, 64'd0);
    check_val("rst_out_flags", {outSop, outEop, outVld, outFrameOk, outFrameErr, outDaMatch}, 6'd0);
    check_val("rst_err_code", outErrCode, 3'd0);
    check_stats();
  endtask

  initial begin
    int kind;
    int len;

    repeat (2) @(negedge clk);
    check_zero();
    resetN = 1'b1;
    @(negedge clk);

    // Good unicast frame addressed to us
    send_frame(10, MY_MAC, 1'b1, 0, 0);
    idle(2);
    check_stats();
    // Broadcast runt, then a single-word frame
    send_frame(5, ETH_BCAST, 1'b1, 0, 0);
    idle(2);
    send_frame(1, MY_MAC, 1'b1, 0, 0);
    idle(2);
    check_stats();
    // Multicast giant: word count must saturate, not wrap
    send_frame(200, MC_MAC, 1'b1, 0, 0);
    idle(2);
    check_stats();
    // SOP at word 4 of an open frame, then a clean 8-word frame
    send_frame(3, pick_da(), 1'b0, 0, 0);
    send_frame(8, MY_MAC, 1'b1, 0, 0);
    idle(2);
    // Back-to-back: interrupting SOP+EOP, then an immediate SOP+EOP in idle
    send_frame(3, pick_da(), 1'b0, 0, 0);
    send_frame(1, ETH_BCAST, 1'b1, 0, 0);
    send_frame(1, MC_MAC, 1'b1, 0, 0);
    idle(3);
    check_stats();
    // Gap just under the limit is fine; a full gap times out and later words are strays
    send_frame(10, MY_MAC, 1'b1, 0, GAP_MAX - 1);
    idle(1);
    send_gap_timeout(6, MY_MAC);
    strays(2);
    check_stats();

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      if (open_frame && kind == 3) kind = 0;
      case (kind)
        0: begin
          len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(185, 200))
                                            : int'($urandom_range(1, 20));
          send_frame(len, pick_da(), 1'b1, GAP_MAX - 1, 0);
          idle($urandom_range(0, 3));
        end
        1: begin
          send_gap_timeout($urandom_range(1, 12), pick_da());
          strays($urandom_range(0, 3));
        end
        2: begin
          send_frame($urandom_range(1, 12), pick_da(), 1'b0, GAP_MAX - 1, 0);
          idle($urandom_range(0, GAP_MAX - 1));
        end
        default: strays($urandom_range(1, 3));
      endcase
      if (!open_frame) check_stats();
    end
    if (open_frame) send_frame(8, MY_MAC, 1'b1, 0, 0);
    idle(3);
    check_stats();

    // Stray counter saturation
    step(1'b0, 1'b0, 1'b0, rnd64(), 1'b0, 1'b1);
    strays(CMAX);
    check_val("stray_at_max", statStray, 16'hFFFF);
    strays(1);
    check_val("stray_saturated", statStray, 16'hFFFF);
    check_stats();
    // Clear wins over a same-cycle increment
    step(1'b1, 1'b0, 1'b0, rnd64(), 1'b1, 1'b1);
    check_val("clr_priority", statStray, 16'h0000);
    check_stats();

    // Asynchronous reset in the middle of a frame
    send_frame(5, MY_MAC, 1'b0, 0, 0);
    resetN = 1'b0;
    #1;
    evq.delete();
    model_clear();
    m_data = '0;
    open_frame = 1'b0;
    last_pulse = cyc;
    check_zero();
    @(negedge clk);
    resetN = 1'b1;
    send_frame(8, MY_MAC, 1'b1, 0, 0);
    idle(3);
    check_stats();

    check_val("events_drained", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
